// File: rtl/mips_dmem_responder_if.sv
// Data-port bundle between the single-cycle MIPS core (master) and its data memory responder (slave).
interface mips_dmem_responder_if;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output memwrite, aluout, writedata, input readdata);
  modport slave  (input memwrite, aluout, writedata, output readdata);
endinterface

// File: rtl/mips_dmem_responder.sv
// Data memory for the MIPS core: word RAM plus an MMIO page with timer/compare/irq and GPIO.
// Optional macro TIMER_PRESCALE_EN divides the timer tick by PRESCALE.
module mips_dmem_responder #(
  parameter int DEPTH    = 64,
  parameter int GPIO_W   = 8,
  parameter int PRESCALE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_dmem_responder_if.slave  bus,
  output logic [GPIO_W-1:0]     gpio_out,
  output logic                  irq
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [14:0] DEPTH_W = 15'(DEPTH);

  logic              ram_sel;
  logic              mmio_sel;
  logic [AW-1:0]     ram_idx;
  logic              we_tcount;
  logic              we_tcmp;
  logic              we_status;
  logic              we_gpio;
  logic              tick;
  logic              unused_addr_bits;

  logic [31:0]       ram_q [DEPTH];
  logic [31:0]       tcount_q, tcount_d;
  logic [31:0]       tcmp_q,   tcmp_d;
  logic              match_q,  match_d;
  logic [GPIO_W-1:0] gpio_q,   gpio_d;
  logic [31:0]       rdata;

  assign ram_sel  = (bus.aluout[31:16] == 16'h0000) && ({1'b0, bus.aluout[15:2]} < DEPTH_W);
  assign mmio_sel = (bus.aluout[31:4] == 28'hFFFF000);
  assign ram_idx  = bus.aluout[AW+1:2];
  assign unused_addr_bits = ^bus.aluout[1:0];

  assign we_tcount = bus.memwrite && mmio_sel && (bus.aluout[3:2] == 2'd0);
  assign we_tcmp   = bus.memwrite && mmio_sel && (bus.aluout[3:2] == 2'd1);
  assign we_status = bus.memwrite && mmio_sel && (bus.aluout[3:2] == 2'd2);
  assign we_gpio   = bus.memwrite && mmio_sel && (bus.aluout[3:2] == 2'd3);

`ifdef TIMER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre_q, pre_d;

  assign tick = (pre_q == PW'(PRESCALE - 1));

  always_comb begin
    pre_d = tick ? '0 : pre_q + PW'(1);
    if (we_tcount) pre_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pre_q <= '0;
    else        pre_q <= pre_d;
  end
`else
  assign tick = 1'b1;
`endif

  // RAM has no reset; gating on reset drops a write caught by an async reset.
  always_ff @(posedge clk) begin
    if (reset && bus.memwrite && ram_sel) ram_q[ram_idx] <= bus.writedata;
  end

  always_comb begin
    tcount_d = tcount_q;
    tcmp_d   = tcmp_q;
    match_d  = match_q;
    gpio_d   = gpio_q;

    if (tick)      tcount_d = tcount_q + 32'd1;
    if (we_tcount) tcount_d = bus.writedata;
    if (we_tcmp)   tcmp_d   = bus.writedata;
    if (we_gpio)   gpio_d   = bus.writedata[GPIO_W-1:0];

    // Clear first so a same-cycle match overrides it.
    if (we_status && bus.writedata[0])  match_d = 1'b0;
    if (tick && (tcount_q == tcmp_q))   match_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcount_q <= 32'h0000_0000;
      tcmp_q   <= 32'hFFFF_FFFF;
      match_q  <= 1'b0;
      gpio_q   <= '0;
    end else begin
      tcount_q <= tcount_d;
      tcmp_q   <= tcmp_d;
      match_q  <= match_d;
      gpio_q   <= gpio_d;
    end
  end

  always_comb begin
    rdata = 32'h0000_0000;
    if (ram_sel) begin
      rdata = ram_q[ram_idx];
    end else if (mmio_sel) begin
      case (bus.aluout[3:2])
        2'd0:    rdata = tcount_q;
        2'd1:    rdata = tcmp_q;
        2'd2:    rdata = {31'b0, match_q};
        default: rdata = 32'(gpio_q);
      endcase
    end
  end

  assign bus.readdata = rdata;
  assign gpio_out     = gpio_q;
  assign irq          = match_q;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Scoreboard bench for mips_dmem_responder: stimulus queues expected values, a negedge monitor compares.
module tb_mips_dmem_responder;

  localparam logic [31:0] A_TCOUNT = 32'hFFFF_0000;
  localparam logic [31:0] A_TCMP   = 32'hFFFF_0004;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0008;
  localparam logic [31:0] A_GPIO   = 32'hFFFF_000C;
  localparam int K_NONE = -1;
  localparam int K_RD   = 0;
  localparam int K_GPIO = 1;
  localparam int K_IRQ  = 2;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       nm;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [7:0] gpio_out;
  logic       irq;
  logic       chk_en;
  exp_t       sb[$];
  int         n_chk;
  int         n_pass;

  mips_dmem_responder_if bus ();

  mips_dmem_responder #(.DEPTH(64), .GPIO_W(8), .PRESCALE(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .gpio_out (gpio_out),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (chk_en) begin
      exp_t        e;
      logic [31:0] act;
      n_chk++;
      if (sb.size() == 0) begin
        $display("FAIL monitor: output presented with empty scoreboard");
      end else begin
        e   = sb.pop_front();
        act = (e.kind == K_RD)   ? bus.readdata :
              (e.kind == K_GPIO) ? 32'(gpio_out) : 32'(irq);
        if (act === e.exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", e.nm, act, e.exp);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One bus cycle; optionally queue an expectation checked mid-cycle.
  task automatic op(input logic we, input logic [31:0] a, input logic [31:0] wd,
                    input int kind, input logic [31:0] exp, input string nm);
    exp_t e;
    bus.memwrite  = we;
    bus.aluout    = a;
    bus.writedata = wd;
    if (kind != K_NONE) begin
      e.kind = kind;
      e.exp  = exp;
      e.nm   = nm;
      sb.push_back(e);
      chk_en = 1'b1;
    end
    cyc();
    chk_en       = 1'b0;
    bus.memwrite = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd);
    op(1'b1, a, wd, K_NONE, 32'h0, "");
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    op(1'b0, a, 32'h0, K_RD, exp, nm);
  endtask

  task automatic pin(input int kind, input logic [31:0] exp, input string nm);
    op(1'b0, 32'h8000_0000, 32'h0, kind, exp, nm);
  endtask

  initial begin
    n_chk         = 0;
    n_pass        = 0;
    chk_en        = 1'b0;
    reset         = 1'b0;
    bus.memwrite  = 1'b0;
    bus.aluout    = 32'h0;
    bus.writedata = 32'h0;
    repeat (2) @(posedge clk);
    #1;

    rd(A_TCOUNT, 32'h0, "rst_tcount");
    rd(A_TCMP, 32'hFFFF_FFFF, "rst_tcmp");
    pin(K_GPIO, 32'h0, "rst_gpio");
    pin(K_IRQ, 32'h0, "rst_irq");

    reset = 1'b1;
    cyc();
`ifndef TIMER_PRESCALE_EN
    rd(A_TCOUNT, 32'h1, "release_tcount");
`endif

    wr(32'h0000_0000, 32'h1111_1111);
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_rd");
    rd(32'h0000_0013, 32'hDEAD_BEEF, "ram_rd_lowbits");
    op(1'b1, 32'h0000_0010, 32'h0BAD_F00D, K_RD, 32'hDEAD_BEEF, "ram_same_cycle_old");
    rd(32'h0000_0010, 32'h0BAD_F00D, "ram_rd_new");
    wr(32'h0000_0100, 32'hCAFE_0001);
    rd(32'h0000_0000, 32'h1111_1111, "ram_beyond_depth_no_alias");
    wr(32'h0001_0000, 32'hCAFE_0002);
    rd(32'h0000_0000, 32'h1111_1111, "unmapped_wr_no_alias");
    rd(32'h0000_0100, 32'h0, "ram_beyond_depth_rd");
    rd(32'h8000_0000, 32'h0, "unmapped_rd");

`ifndef TIMER_PRESCALE_EN
    wr(A_TCMP, 32'h0000_1000);
    rd(A_TCMP, 32'h0000_1000, "tcmp_rb");
    wr(A_TCOUNT, 32'hFFFF_FFFE);
    rd(A_TCOUNT, 32'hFFFF_FFFE, "tcount_load");
    rd(A_TCOUNT, 32'hFFFF_FFFF, "tcount_inc");
    rd(A_TCOUNT, 32'h0000_0000, "tcount_wrap");

    wr(A_TCMP, 32'h5);
    wr(A_STATUS, 32'h1);
    wr(A_TCOUNT, 32'h0);
    repeat (5) cyc();
    pin(K_IRQ, 32'h0, "irq_at_match_cycle");
    pin(K_IRQ, 32'h1, "irq_rise");
    op(1'b1, A_STATUS, 32'h0, K_IRQ, 32'h1, "irq_w0_same");
    pin(K_IRQ, 32'h1, "irq_w0_sticky");
    wr(A_STATUS, 32'h1);
    pin(K_IRQ, 32'h0, "irq_w1c");
    rd(A_STATUS, 32'h0, "status_clear_rb");

    wr(A_TCMP, 32'h102);
    wr(A_TCOUNT, 32'h100);
    cyc();
    pin(K_IRQ, 32'h0, "irq_pre_collision");
    wr(A_STATUS, 32'h1);
    pin(K_IRQ, 32'h1, "collision_set_wins");
    rd(A_STATUS, 32'h1, "status_set_rb");
`else
    wr(A_TCOUNT, 32'h0);
    rd(A_TCOUNT, 32'h0, "pre_t0");
    rd(A_TCOUNT, 32'h0, "pre_t1");
    rd(A_TCOUNT, 32'h0, "pre_t2");
    rd(A_TCOUNT, 32'h0, "pre_t3");
    rd(A_TCOUNT, 32'h1, "pre_tick");
`endif

    wr(A_GPIO, 32'h0000_01A5);
    pin(K_GPIO, 32'h0000_00A5, "gpio_out");
    rd(A_GPIO, 32'h0000_00A5, "gpio_rb");

    reset = 1'b0;
    op(1'b1, A_GPIO, 32'h0000_00FF, K_GPIO, 32'h0, "midrst_gpio");
    rd(A_TCOUNT, 32'h0, "midrst_tcount");
    rd(A_TCMP, 32'hFFFF_FFFF, "midrst_tcmp");
    pin(K_IRQ, 32'h0, "midrst_irq");
    reset = 1'b1;
    pin(K_GPIO, 32'h0, "midrst_write_aborted");
    rd(32'h0000_0010, 32'h0BAD_F00D, "ram_survives_reset");

    @(negedge clk);
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mips_dmem_responder.md
Name: mips_dmem_responder

Overview:
Data-memory responder for the single-cycle MIPS core's data port. It services the core's memwrite/aluout/writedata/readdata interface.
- Word RAM with combinational read and clocked write.
- Memory-mapped I/O page: free-running timer, compare match with interrupt, and GPIO output register.
- Sits beside the core at the top level. The core drives address/data; this block returns readdata in the same cycle.

Parameters:
- DEPTH, 64, RAM size in 32-bit words; power of 2, 4..4096.
- GPIO_W, 8, width of GPIO output register (1..32).
- PRESCALE, 4, timer tick divisor; used only with TIMER_PRESCALE_EN; must be >=1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- memwrite  input  1  write strobe from core, sampled on rising clk.
- aluout  input  32  byte address from core; bits [1:0] ignored.
- writedata  input  32  write data from core.
- readdata  output  32  read data to core, combinational from aluout.
- gpio_out  output  GPIO_W  GPIO output register.
- irq  output  1  timer match interrupt, equal to STATUS.match.

Behaviour:
- Address decode, word index = aluout[31:2]:
  - RAM: aluout[31:16]==16'h0000 and word index < DEPTH.
  - MMIO: aluout[31:4]==28'hFFFF000.
  - Everything else is unmapped.
- MMIO register map:
  - 0xFFFF0000 TCOUNT, RW.
  - 0xFFFF0004 TCMP, RW.
  - 0xFFFF0008 STATUS, bit0 match: RO set, W1C.
  - 0xFFFF000C GPIO, RW, low GPIO_W bits.
- Reads are combinational and have zero latency:
  - readdata reflects the current register/RAM value for aluout in the same cycle.
  - Unmapped reads return 32'h0.
  - Unused STATUS and GPIO bits read as 0.
- Writes commit on rising clk when memwrite=1. Unmapped writes and writes to RAM beyond DEPTH are ignored.
- RAM:
  - Not cleared by reset; contents are X until written.
  - A read of the address written in the same cycle returns the old value until the edge.
- Timer:
  - TCOUNT increments by 1 every clk; 32-bit wrap 0xFFFFFFFF -> 0x00000000.
  - A write to TCOUNT loads writedata and overrides the increment that cycle.
  - The next cycle continues from the loaded value + 1.
- Match:
  - When the TCOUNT register value equals TCMP (pre-increment compare), STATUS.match sets on the following edge.
  - Match is sticky until cleared.
- Clearing STATUS:
  - Writing STATUS with writedata[0]=1 clears match; writedata[0]=0 has no effect.
  - If set and clear occur in the same cycle, set wins.
- TCMP write takes effect for the compare from the next cycle.
- Reset (async assert, sync-to-clk release is the top level's job):
  - TCOUNT=0, TCMP=32'hFFFFFFFF, match=0, gpio_out=0, irq=0.
  - readdata follows the decode, e.g. TCOUNT reads 0 during reset.
  - Reset mid-operation aborts any pending write; no partial state.
- irq is a registered output: irq == match, with no additional latency.

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- Defined:
  - An internal prescale counter counts 0..PRESCALE-1 and is reset to 0.
  - TCOUNT increments only when the prescale counter is at PRESCALE-1, then the prescale counter wraps to 0.
  - A write to TCOUNT also clears the prescale counter.
  - The match compare is evaluated only on tick cycles.
- Not defined: TCOUNT increments every clk as above; no prescale logic is present.

Test Plan:
- RAM write/read: write 0xDEADBEEF to 0x00000010, then read 0x00000010 -> 0xDEADBEEF. Read 0x00000013 -> 0xDEADBEEF (low bits ignored). Write to 0x00000100 with DEPTH=64 -> ignored, no aliasing to word 0.
- Reset values: hold reset=0 mid-run -> TCOUNT reads 0, TCMP reads 0xFFFFFFFF, gpio_out=0, irq=0 immediately (async). Release -> TCOUNT reads 1 after the first edge.
- Timer load/wrap: write TCOUNT=0xFFFFFFFE -> after 2 edges reads 0x00000000. A write in the same cycle as an increment loads the written value.
- Compare/irq: TCOUNT=0, TCMP=5 -> irq rises on the edge after TCOUNT==5 and stays high. Write STATUS=0x0 -> irq stays 1. Write STATUS=0x1 -> irq=0.
- Set/clear collision: W1C to STATUS in the same cycle the compare matches -> match remains 1.
- GPIO/unmapped: write 0x1A5 to 0xFFFF000C -> gpio_out=0xA5 and readback 0x000000A5. Read 0x80000000 -> 0. With TIMER_PRESCALE_EN and PRESCALE=4, TCOUNT advances by 1 per 4 clks.
